accel_spi_responder: RTL and testbench

//  SPI slave (responder) emulating the board accelerometer's register interface (ADXL362-style read/write commands).

---
 rtl/accel_spi_pkg.sv | 35 +++
 rtl/accel_spi_responder_if.sv | 18 +
 rtl/accel_spi_responder_in_sync.sv | 35 +++
 rtl/accel_spi_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_accel_spi_responder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/accel_spi_pkg.sv
// Shared definitions for the accelerometer SPI responder: command codes,
// register addresses and the transaction FSM state type.
package accel_spi_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    localparam logic [5:0] REG_DEVID_AD   = 6'h00;
    localparam logic [5:0] REG_DEVID_MST  = 6'h01;
    localparam logic [5:0] REG_PARTID     = 6'h02;
    localparam logic [5:0] REG_XDATA      = 6'h08;
    localparam logic [5:0] REG_YDATA      = 6'h09;
    localparam logic [5:0] REG_ZDATA      = 6'h0A;
    localparam logic [5:0] REG_STATUS     = 6'h0B;
    localparam logic [5:0] REG_FILTER_CTL = 6'h2C;
    localparam logic [5:0] REG_POWER_CTL  = 6'h2D;

    localparam logic [7:0] FILTER_CTL_RST = 8'h13;
    localparam logic [7:0] POWER_CTL_RST  = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_RD,
        ADDR_WR,
        DATA_RD,
        DATA_WR,
        IGNORE
    } spi_state_e;

    function automatic logic reg_writable(input logic [5:0] addr);
        return (addr == REG_FILTER_CTL) || (addr == REG_POWER_CTL);
    endfunction

endpackage

// File: rtl/accel_spi_responder_if.sv
// SPI bus between an accelerometer master and the responder.
interface accel_spi_responder_if;
    logic spi_csn;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_csn, spi_sclk, spi_mosi,
        input  spi_miso, spi_miso_oe
    );

    modport slave (
        input  spi_csn, spi_sclk, spi_mosi,
        output spi_miso, spi_miso_oe
    );
endinterface

// File: rtl/accel_spi_responder_in_sync.sv
// Multi-stage synchroniser for one SPI pin with rise/fall detection on the
// synchronised value.
module spi_in_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic arst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;
endmodule

// File: rtl/accel_spi_responder.sv
// Oversampled SPI responder emulating the accelerometer register interface.
// Define ACCEL_SPI_RESP_WRITE_EN to make regs 0x2C/0x2D writable over SPI.
module accel_spi_responder
    import accel_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID_AD    = 8'hAD,
    parameter logic [7:0]  DEVID_MST   = 8'h1D,
    parameter logic [7:0]  PARTID      = 8'hF2
) (
    input  logic                        clk,
    input  logic                        arst_n,
    accel_spi_responder_if.slave        spi,
    input  logic [7:0]                  accel_x,
    input  logic [7:0]                  accel_y,
    input  logic [7:0]                  accel_z,
    input  logic                        data_valid,
    output logic [7:0]                  power_ctl,
    output logic [7:0]                  filter_ctl,
    output logic                        xfer_done,
    output logic                        cmd_err
);
    logic csn_s, csn_rise, csn_fall;
    logic sclk_s_unused, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    // CSN idles high so leaving reset never produces a false transaction start.
    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .clk(clk), .arst_n(arst_n), .din(spi.spi_csn),
        .dout(csn_s), .rise(csn_rise), .fall(csn_fall)
    );
    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .arst_n(arst_n), .din(spi.spi_sclk),
        .dout(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .arst_n(arst_n), .din(spi.spi_mosi),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [5:0] addr_q, addr_d;
    logic       miso_q, miso_d;
    logic       oe_q, oe_d;
    logic [7:0] shx_q, shx_d, shy_q, shy_d, shz_q, shz_d;
    logic       data_ready_q, data_ready_d;
    logic       x_read_q, x_read_d;
    logic       xfer_done_q, xfer_done_d;
    logic       cmd_err_q, cmd_err_d;
`ifdef ACCEL_SPI_RESP_WRITE_EN
    logic [7:0] power_q, power_d;
    logic [7:0] filter_q, filter_d;
`endif

    logic [7:0] rx_byte;
    logic [5:0] rd_addr;
    logic [7:0] rd_byte;

    assign rx_byte = {rx_q, mosi_s};
    assign rd_addr = (state_q == ADDR_RD) ? rx_byte[5:0] : addr_q + 6'd1;

    always_comb begin
        rd_byte = '0;
        case (rd_addr)
            REG_DEVID_AD:   rd_byte = DEVID_AD;
            REG_DEVID_MST:  rd_byte = DEVID_MST;
            REG_PARTID:     rd_byte = PARTID;
            REG_XDATA:      rd_byte = shx_q;
            REG_YDATA:      rd_byte = shy_q;
            REG_ZDATA:      rd_byte = shz_q;
            REG_STATUS:     rd_byte = {7'b0, data_ready_q};
            REG_FILTER_CTL: rd_byte = filter_ctl;
            REG_POWER_CTL:  rd_byte = power_ctl;
            default:        rd_byte = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        addr_d       = addr_q;
        miso_d       = miso_q;
        oe_d         = oe_q;
        shx_d        = shx_q;
        shy_d        = shy_q;
        shz_d        = shz_q;
        x_read_d     = x_read_q;
        xfer_done_d  = 1'b0;
        cmd_err_d    = 1'b0;
        data_ready_d = data_ready_q;
`ifdef ACCEL_SPI_RESP_WRITE_EN
        power_d      = power_q;
        filter_d     = filter_q;
`endif

        // A fresh sample arriving on the same cycle as the clear must survive.
        if (csn_rise && x_read_q)
            data_ready_d = 1'b0;
        if (data_valid)
            data_ready_d = 1'b1;

        if (csn_fall) begin
            state_d   = CMD;
            bit_cnt_d = '0;
            shx_d     = accel_x;
            shy_d     = accel_y;
            shz_d     = accel_z;
            oe_d      = 1'b1;
            miso_d    = 1'b0;
            x_read_d  = 1'b0;
        end else if (csn_rise) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            oe_d        = 1'b0;
            miso_d      = 1'b0;
            xfer_done_d = 1'b1;
        end else if (state_q != IDLE) begin
            if (sclk_rise) begin
                rx_d      = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    case (state_q)
                        CMD: begin
                            if (rx_byte == CMD_READ)
                                state_d = ADDR_RD;
                            else if (rx_byte == CMD_WRITE)
                                state_d = ADDR_WR;
                            else begin
                                cmd_err_d = 1'b1;
                                state_d   = IGNORE;
                            end
                        end
                        ADDR_RD, DATA_RD: begin
                            addr_d  = rd_addr;
                            tx_d    = rd_byte;
                            state_d = DATA_RD;
                            if (rd_addr == REG_XDATA)
                                x_read_d = 1'b1;
                        end
                        ADDR_WR: begin
                            addr_d = rx_byte[5:0];
`ifdef ACCEL_SPI_RESP_WRITE_EN
                            state_d = DATA_WR;
`else
                            state_d = IGNORE;
`endif
                        end
                        DATA_WR: begin
`ifdef ACCEL_SPI_RESP_WRITE_EN
                            if (reg_writable(addr_q)) begin
                                if (addr_q == REG_POWER_CTL)
                                    power_d = rx_byte;
                                else
                                    filter_d = rx_byte;
                            end
`endif
                            addr_d = addr_q + 6'd1;
                        end
                        default: ;
                    endcase
                end
            end
            if (sclk_fall && (state_q == DATA_RD)) begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            addr_q       <= '0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            shx_q        <= '0;
            shy_q        <= '0;
            shz_q        <= '0;
            data_ready_q <= 1'b0;
            x_read_q     <= 1'b0;
            xfer_done_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            miso_q       <= miso_d;
            oe_q         <= oe_d;
            shx_q        <= shx_d;
            shy_q        <= shy_d;
            shz_q        <= shz_d;
            data_ready_q <= data_ready_d;
            x_read_q     <= x_read_d;
            xfer_done_q  <= xfer_done_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

`ifdef ACCEL_SPI_RESP_WRITE_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            power_q  <= POWER_CTL_RST;
            filter_q <= FILTER_CTL_RST;
        end else begin
            power_q  <= power_d;
            filter_q <= filter_d;
        end
    end

    assign power_ctl  = power_q;
    assign filter_ctl = filter_q;
`else
    assign power_ctl  = POWER_CTL_RST;
    assign filter_ctl = FILTER_CTL_RST;
`endif

    assign spi.spi_miso    = miso_q;
    assign spi.spi_miso_oe = oe_q;
    assign xfer_done       = xfer_done_q;
    assign cmd_err         = cmd_err_q;
endmodule

// File: tb/tb_accel_spi_responder.sv
// Directed bench for accel_spi_responder: table of SPI transactions plus
// hand-written sequences for mid-transaction sampling, abort and reset.
module tb_accel_spi_responder;
    logic       clk = 1'b0;
    logic       arst_n;
    logic [7:0] accel_x, accel_y, accel_z;
    logic       data_valid;
    logic [7:0] power_ctl, filter_ctl;
    logic       xfer_done, cmd_err;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned done_cnt = 0;
    int unsigned err_cnt = 0;

`ifdef ACCEL_SPI_RESP_WRITE_EN
    localparam logic [7:0] PWR_EXP = 8'h02;
`else
    localparam logic [7:0] PWR_EXP = 8'h00;
`endif

    accel_spi_responder_if spi_bus ();

    accel_spi_responder #(
        .SYNC_STAGES(2),
        .DEVID_AD   (8'hAD),
        .DEVID_MST  (8'h1D),
        .PARTID     (8'hF2)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .spi        (spi_bus),
        .accel_x    (accel_x),
        .accel_y    (accel_y),
        .accel_z    (accel_z),
        .data_valid (data_valid),
        .power_ctl  (power_ctl),
        .filter_ctl (filter_ctl),
        .xfer_done  (xfer_done),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (xfer_done) done_cnt++;
        if (cmd_err)   err_cnt++;
    end

    typedef struct {
        int unsigned half;
        int unsigned nbytes;
        logic [47:0] tx;
        logic [47:0] exp;
        bit          pre_valid;
        int unsigned exp_err;
        logic [7:0]  exp_pwr;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input int unsigned half, input int unsigned n,
                           input logic [47:0] tx, input logic [47:0] exp, input bit pv,
                           input int unsigned er, input logic [7:0] pwr);
        vecs[idx].half      = half;
        vecs[idx].nbytes    = n;
        vecs[idx].tx        = tx;
        vecs[idx].exp       = exp;
        vecs[idx].pre_valid = pv;
        vecs[idx].exp_err   = er;
        vecs[idx].exp_pwr   = pwr;
    endtask

    task automatic pulse_valid();
        @(negedge clk) data_valid = 1'b1;
        @(negedge clk) data_valid = 1'b0;
    endtask

    task automatic spi_begin(input int unsigned half);
        spi_bus.spi_sclk = 1'b0;
        spi_bus.spi_csn  = 1'b0;
        repeat (half + 4) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int unsigned nbits,
                            input int unsigned half, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - int'(nbits); i--) begin
            spi_bus.spi_mosi = tx[i];
            repeat (half) @(negedge clk);
            rx[i] = spi_bus.spi_miso;
            spi_bus.spi_sclk = 1'b1;
            repeat (half) @(negedge clk);
            spi_bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_end(input int unsigned half);
        repeat (half) @(negedge clk);
        spi_bus.spi_csn = 1'b1;
        repeat (half + 8) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rx;
        int unsigned d0, e0;

        arst_n = 1'b0;
        spi_bus.spi_csn  = 1'b1;
        spi_bus.spi_sclk = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        accel_x = 8'h12;
        accel_y = 8'hFE;
        accel_z = 8'h80;
        data_valid = 1'b0;

        // tx/exp bytes are listed MSB-first; cmd/addr phases expect MISO=0
        set_vec(0, 8, 5, {8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                         {8'h00, 8'h00, 8'hAD, 8'h1D, 8'hF2, 8'h00}, 0, 0, 8'h00);
        set_vec(1, 3, 6, {8'h0B, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00},
                         {8'h00, 8'h00, 8'h12, 8'hFE, 8'h80, 8'h01}, 1, 0, 8'h00);
        set_vec(2, 8, 3, {8'h0B, 8'h0B, 8'h00, 24'h0},
                         {8'h00, 8'h00, 8'h00, 24'h0}, 0, 0, 8'h00);
        set_vec(3, 3, 4, {8'h0C, 8'h00, 8'h00, 8'h00, 16'h0},
                         {8'h00, 8'h00, 8'h00, 8'h00, 16'h0}, 0, 1, 8'h00);
        set_vec(4, 8, 4, {8'h0B, 8'h3F, 8'h00, 8'h00, 16'h0},
                         {8'h00, 8'h00, 8'h00, 8'hAD, 16'h0}, 0, 0, 8'h00);
        set_vec(5, 3, 3, {8'h0A, 8'h2D, 8'h02, 24'h0},
                         {8'h00, 8'h00, 8'h00, 24'h0}, 0, 0, PWR_EXP);
        set_vec(6, 3, 3, {8'h0A, 8'h08, 8'h77, 24'h0},
                         {8'h00, 8'h00, 8'h00, 24'h0}, 0, 0, PWR_EXP);
        set_vec(7, 8, 3, {8'h0B, 8'h08, 8'h00, 24'h0},
                         {8'h00, 8'h00, 8'h12, 24'h0}, 0, 0, PWR_EXP);
        set_vec(8, 3, 4, {8'h0B, 8'h2C, 8'h00, 8'h00, 16'h0},
                         {8'h00, 8'h00, 8'h13, PWR_EXP, 16'h0}, 0, 0, PWR_EXP);

        repeat (3) @(negedge clk);
        check("rst miso",       {7'b0, spi_bus.spi_miso},    8'h00);
        check("rst miso_oe",    {7'b0, spi_bus.spi_miso_oe}, 8'h00);
        check("rst power_ctl",  power_ctl,                   8'h00);
        check("rst filter_ctl", filter_ctl,                  8'h13);
        check("rst xfer_done",  {7'b0, xfer_done},           8'h00);
        check("rst cmd_err",    {7'b0, cmd_err},             8'h00);
        arst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].pre_valid) pulse_valid();
            d0 = done_cnt;
            e0 = err_cnt;
            spi_begin(vecs[v].half);
            check($sformatf("vec%0d oe during xfer", v), {7'b0, spi_bus.spi_miso_oe}, 8'h01);
            for (int b = 0; b < int'(vecs[v].nbytes); b++) begin
                spi_bits(vecs[v].tx[47-8*b -: 8], 8, vecs[v].half, rx);
                check($sformatf("vec%0d byte%0d", v, b), rx, vecs[v].exp[47-8*b -: 8]);
            end
            spi_end(vecs[v].half);
            check($sformatf("vec%0d xfer_done pulses", v), 8'(done_cnt - d0), 8'd1);
            check($sformatf("vec%0d cmd_err pulses", v), 8'(err_cnt - e0), 8'(vecs[v].exp_err));
            check($sformatf("vec%0d power_ctl", v), power_ctl, vecs[v].exp_pwr);
            check($sformatf("vec%0d oe after xfer", v), {7'b0, spi_bus.spi_miso_oe}, 8'h00);
        end

        // New sample mid-transaction must not disturb the shadow copy.
        spi_begin(3);
        spi_bits(8'h0B, 8, 3, rx);
        spi_bits(8'h07, 8, 3, rx);
        spi_bits(8'h00, 8, 3, rx);
        check("midvalid reg07", rx, 8'h00);
        accel_x = 8'h55;
        pulse_valid();
        spi_bits(8'h00, 8, 3, rx);
        check("midvalid shadow x", rx, 8'h12);
        spi_end(3);
        spi_begin(8);
        spi_bits(8'h0B, 8, 8, rx);
        spi_bits(8'h08, 8, 8, rx);
        spi_bits(8'h00, 8, 8, rx);
        check("next x", rx, 8'h55);
        spi_bits(8'h00, 8, 8, rx);
        check("next y", rx, 8'hFE);
        spi_bits(8'h00, 8, 8, rx);
        check("next z", rx, 8'h80);
        spi_bits(8'h00, 8, 8, rx);
        check("next status cleared", rx, 8'h00);
        spi_end(8);

        // Abort partway through a write data byte.
        d0 = done_cnt;
        spi_begin(3);
        spi_bits(8'h0A, 8, 3, rx);
        spi_bits(8'h2C, 8, 3, rx);
        spi_bits(8'hFF, 5, 3, rx);
        spi_end(3);
        check("abort xfer_done", 8'(done_cnt - d0), 8'd1);
        check("abort filter_ctl", filter_ctl, 8'h13);
        check("abort oe", {7'b0, spi_bus.spi_miso_oe}, 8'h00);
        spi_begin(3);
        spi_bits(8'h0B, 8, 3, rx);
        spi_bits(8'h2C, 8, 3, rx);
        spi_bits(8'h00, 8, 3, rx);
        check("abort readback", rx, 8'h13);
        spi_end(3);

        // Asynchronous reset in the middle of a read.
        spi_begin(8);
        spi_bits(8'h0B, 8, 8, rx);
        spi_bits(8'h00, 8, 8, rx);
        spi_bits(8'h00, 4, 8, rx);
        arst_n = 1'b0;
        #1;
        check("arst oe", {7'b0, spi_bus.spi_miso_oe}, 8'h00);
        check("arst miso", {7'b0, spi_bus.spi_miso}, 8'h00);
        check("arst power_ctl", power_ctl, 8'h00);
        spi_bus.spi_csn  = 1'b1;
        spi_bus.spi_sclk = 1'b0;
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        repeat (5) @(negedge clk);
        spi_begin(3);
        spi_bits(8'h0B, 8, 3, rx);
        spi_bits(8'h00, 8, 3, rx);
        spi_bits(8'h00, 8, 3, rx);
        check("post-rst id0", rx, 8'hAD);
        spi_bits(8'h00, 8, 3, rx);
        check("post-rst id1", rx, 8'h1D);
        spi_bits(8'h00, 8, 3, rx);
        check("post-rst id2", rx, 8'hF2);
        spi_end(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
